// File: rtl/test_mem_subsystem.sv
// test_mem_subsystem: dual-port word RAM (imem fetch, dmem load/store, 1-cycle read-before-write) plus tohost pass/fail decode, RUN/DONE/TIMEOUT status FSM and saturating cycle counter
module test_mem_subsystem #(
  parameter int MEM_WIDTH = 13,
  parameter string INIT_FILE = "",
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] imem_addr_i,
  input  logic        imem_read_n_i,
  output logic [31:0] imem_data_o,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_data_i,
  input  logic [3:0]  dmem_be_i,
  input  logic        dmem_write_i,
  input  logic        dmem_read_i,
  output logic [31:0] dmem_data_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [30:0] fail_code_o,
  output logic        timeout_o,
  output logic [31:0] cycle_count_o
);
  localparam int DEPTH = 1 << (MEM_WIDTH - 2);
  localparam logic [31:0] LIMIT = 32'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {RUN, DONE, TIMEOUT} state_t;
  state_t state, state_nxt;
  logic [31:0] mem [DEPTH];
  logic [31:0] tohost;
  logic [MEM_WIDTH-3:0] i_idx, d_idx;
  logic hit, store, to_wr, term, unused_addr;
  assign i_idx = imem_addr_i[MEM_WIDTH-1:2];
  assign d_idx = dmem_addr_i[MEM_WIDTH-1:2];
  assign hit = dmem_addr_i[31:2] == TOHOST_ADDR[31:2];
  assign store = reset_n && dmem_write_i && !hit;
  assign to_wr = dmem_write_i && hit && |dmem_be_i && state == RUN;
  assign term = to_wr && dmem_data_i[0];
  assign unused_addr = ^{imem_addr_i[31:MEM_WIDTH], imem_addr_i[1:0], dmem_addr_i[1:0]};
  assign done_o = state == DONE;
  assign timeout_o = state == TIMEOUT;
  always_ff @(posedge clk)
    for (int b = 0; b < 4; b++)
      if (store && dmem_be_i[b]) mem[d_idx][8*b +: 8] <= dmem_data_i[8*b +: 8];
  always_ff @(posedge clk)
    if (!reset_n) begin
      imem_data_o <= '0;
      dmem_data_o <= '0;
    end else begin
      if (!imem_read_n_i) imem_data_o <= mem[i_idx];
      if (dmem_read_i && !dmem_write_i) dmem_data_o <= hit ? tohost : mem[d_idx];
    end
  always_comb
    state_nxt = state != RUN ? state : term ? DONE : cycle_count_o == LIMIT ? TIMEOUT : RUN;
  always_ff @(posedge clk)
    state <= !reset_n ? RUN : state_nxt;
  always_ff @(posedge clk)
    if (!reset_n) begin
      tohost <= '0;
      pass_o <= 1'b0;
      fail_code_o <= '0;
      cycle_count_o <= '0;
    end else begin
      if (to_wr) tohost <= dmem_data_i;
      if (term) begin
        pass_o <= dmem_data_i == 32'd1;
        fail_code_o <= dmem_data_i[31:1];
      end
      if (state == RUN && cycle_count_o != '1) cycle_count_o <= cycle_count_o + 32'd1;
    end
endmodule

// File: tb/tb_test_mem_subsystem.sv
// tb_test_mem_subsystem: randomized and directed checks of test_mem_subsystem against a behavioural model
module tb_test_mem_subsystem;
  localparam logic [31:0] TOHOST = 32'h0000_1000;
  localparam int TO = 20;
  logic clk = 1'b0;
  logic reset_n, imem_read_n_i, dmem_write_i, dmem_read_i, done_o, pass_o, timeout_o;
  logic [31:0] imem_addr_i, imem_data_o, dmem_addr_i, dmem_data_i, dmem_data_o, cycle_count_o;
  logic [3:0] dmem_be_i;
  logic [30:0] fail_code_o;
  logic [31:0] m_mem [2048];
  logic [31:0] m_imem, m_dmem, m_th, m_cnt, saved;
  logic [30:0] m_fc;
  logic m_done, m_pass, m_to;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  test_mem_subsystem #(.MEM_WIDTH(13), .INIT_FILE(""), .TOHOST_ADDR(TOHOST), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_addr_i(imem_addr_i), .imem_read_n_i(imem_read_n_i), .imem_data_o(imem_data_o),
    .dmem_addr_i(dmem_addr_i), .dmem_data_i(dmem_data_i), .dmem_be_i(dmem_be_i),
    .dmem_write_i(dmem_write_i), .dmem_read_i(dmem_read_i), .dmem_data_o(dmem_data_o),
    .done_o(done_o), .pass_o(pass_o), .fail_code_o(fail_code_o),
    .timeout_o(timeout_o), .cycle_count_o(cycle_count_o)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic rn, input logic ird_n, input logic [31:0] ia, input logic [31:0] da,
                      input logic [31:0] dd, input logic [3:0] be, input logic wr, input logic rd);
    int iw, dw;
    logic hit, run, term;
    reset_n = rn; imem_read_n_i = ird_n; imem_addr_i = ia; dmem_addr_i = da;
    dmem_data_i = dd; dmem_be_i = be; dmem_write_i = wr; dmem_read_i = rd;
    @(posedge clk);
    if (!rn) begin
      m_imem = 0; m_dmem = 0; m_th = 0; m_fc = 0; m_cnt = 0;
      m_done = 0; m_pass = 0; m_to = 0;
    end else begin
      iw = int'(ia[12:2]);
      dw = int'(da[12:2]);
      hit = da[31:2] == TOHOST[31:2];
      run = !m_done && !m_to;
      term = 0;
      if (!ird_n) m_imem = m_mem[iw];
      if (rd && !wr) m_dmem = hit ? m_th : m_mem[dw];
      if (wr && !hit)
        for (int b = 0; b < 4; b++) if (be[b]) m_mem[dw][8*b +: 8] = dd[8*b +: 8];
      if (run && wr && hit && be != 0) begin
        m_th = dd;
        if (dd[0]) begin
          term = 1; m_done = 1; m_pass = dd == 1; m_fc = dd[31:1];
        end
      end
      if (run) begin
        if (!term && m_cnt == TO - 1) m_to = 1;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end
    end
    #1;
    check("imem_data", imem_data_o, m_imem);
    check("dmem_data", dmem_data_o, m_dmem);
    check("done", {31'd0, done_o}, {31'd0, m_done});
    check("pass", {31'd0, pass_o}, {31'd0, m_pass});
    check("fail_code", {1'b0, fail_code_o}, {1'b0, m_fc});
    check("timeout", {31'd0, timeout_o}, {31'd0, m_to});
    check("cycle_count", cycle_count_o, m_cnt);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic rst();
    step(0, 1, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic wr_tohost(input logic [31:0] v);
    step(1, 1, 0, TOHOST, v, 4'hF, 1, 0);
  endtask
  function automatic logic [31:0] rand_addr();
    int s = $urandom_range(0, 3);
    logic [31:0] a = $urandom;
    return s == 0 ? (TOHOST | (a & 32'h3)) : s == 1 ? ((a & 32'hFFFF_E003) | (32'($urandom_range(0, 7)) << 2)) :
           s == 2 ? (32'($urandom_range(0, 7)) << 2) : a;
  endfunction
  initial begin
    rst(); rst();
    idle(22);
    check("timeout_hit", {31'd0, timeout_o}, 32'd1);
    check("timeout_cnt", cycle_count_o, 32'd20);
    rst();
    idle(TO - 1);
    wr_tohost(1);
    check("race_done", {31'd0, done_o}, 32'd1);
    check("race_timeout", {31'd0, timeout_o}, 32'd0);
    check("race_cnt", cycle_count_o, 32'd20);
    rst();
    check("rst_done", {31'd0, done_o}, 32'd0);
    idle(1);
    check("restart_cnt", cycle_count_o, 32'd1);
    rst();
    for (int w = 0; w < 2048; w++) step(1, 1, 0, 32'h4000_0000 | (w << 2), $urandom, 4'hF, 1, 0);
    step(1, 1, 0, 32'h40, 0, 4'hF, 1, 0);
    step(1, 0, 32'h40, 32'h40, 32'hAABB_CCDD, 4'b0101, 1, 0);
    check("collide_fetch", imem_data_o, 32'h0);
    step(1, 1, 0, 32'h40, 0, 0, 0, 1);
    check("be_load", dmem_data_o, 32'h00BB_00DD);
    step(1, 1, 0, 32'h80, 5, 4'hF, 1, 1);
    check("rw_hold", dmem_data_o, 32'h00BB_00DD);
    step(1, 1, 0, 32'h80, 0, 0, 0, 1);
    check("rw_load", dmem_data_o, 32'd5);
    rst();
    wr_tohost(1);
    check("pass_done", {31'd0, done_o}, 32'd1);
    check("pass_pass", {31'd0, pass_o}, 32'd1);
    saved = cycle_count_o;
    idle(3);
    wr_tohost(7);
    check("frozen_cnt", cycle_count_o, saved);
    check("frozen_pass", {31'd0, pass_o}, 32'd1);
    rst();
    wr_tohost(7);
    check("fail_pass", {31'd0, pass_o}, 32'd0);
    check("fail_code3", {1'b0, fail_code_o}, 32'd3);
    rst();
    wr_tohost(2);
    step(1, 1, 0, TOHOST, 0, 0, 0, 1);
    check("even_done", {31'd0, done_o}, 32'd0);
    check("th_load", dmem_data_o, 32'd2);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] d = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 8)) : $urandom;
      step($urandom_range(0, 29) != 0, 1'($urandom), rand_addr(), rand_addr(), d,
           4'($urandom), $urandom_range(0, 2) == 0, 1'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
